stack_arbiter: RTL
==================

# stack_arbiter

Controller that shares one single-port synchronous stack RAM between the data stack and the routine (return) stack of the StackArch core. It owns both stack pointers and computes full/empty status. It arbitrates push/pop requests from the two requesters with round-robin priority and sequences the RAM accesses through a small FSM. It replaces direct push/pop strobes and FSM-held pointer bookkeeping with a req/ack handshake.

## Interface
Parameters:
- DATA_WIDTH, 16, data stack word width
- RTN_WIDTH, 11, routine stack word width (instruction address); must be ≤ DATA_WIDTH
- DS_DEPTH, 32, data stack entries
- RS_DEPTH, 16, routine stack entries
- ADDR_WIDTH, $clog2(DS_DEPTH+RS_DEPTH), RAM address width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ds_push, ds_pop  in  1  data stack request; level, held until ds_ack
- ds_din  in  DATA_WIDTH  push data
- ds_dout  out  DATA_WIDTH  popped data, held until next pop completes
- ds_ack  out  1  one-cycle completion pulse
- ds_err  out  1  valid with ds_ack; operation rejected
- rs_push, rs_pop, rs_din[RTN_WIDTH], rs_dout[RTN_WIDTH], rs_ack, rs_err  same semantics for the routine stack
- ds_count  out  $clog2(DS_DEPTH+1)  data stack occupancy
- rs_count  out  $clog2(RS_DEPTH+1)  routine stack occupancy
- ds_full, ds_empty, rs_full, rs_empty  out  1  combinational from the counts
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_WIDTH  RAM write data; routine words are zero-extended
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after the address

## Operation
- RAM map: data stack occupies 0..DS_DEPTH-1; routine stack occupies DS_DEPTH..DS_DEPTH+RS_DEPTH-1. Each pointer is the next free slot, relative to the region base.
- FSM states: IDLE, WR, RD, WAIT, RESP.
- IDLE: samples requests.
  - If both requesters are active, grant goes to the one not granted last. The last-grant bit resets to "routine", so the data stack wins the first tie.
  - Granted push, stack not full → WR.
  - Granted pop, stack not empty → RD.
  - Push when full, pop when empty, or push and pop asserted together → RESP with err=1. No RAM access and no pointer change.
- WR: mem_we=1, mem_addr=base+ptr, mem_wdata=din. ptr increments at the clock edge. ack=1 in this cycle → IDLE.
- RD: mem_addr=base+ptr-1; ptr decrements at the clock edge → WAIT.
- WAIT: mem_rdata is loaded into the granted dout register (routine: low RTN_WIDTH bits) → RESP.
- RESP: ack=1 for the granted requester; err=1 if the operation was rejected → IDLE.
- Handshake: one request yields exactly one ack. A request still high in the cycle after ack is treated as a new operation.
- Request changes between sampling and ack are ignored, because the granted op and din are latched in IDLE.
- Reset values: state IDLE, pointers 0, ds_dout/rs_dout 0, all acks/errs/mem_we 0, mem_addr 0, empty flags 1, full flags 0.
- Reset mid-operation: the access is aborted, mem_we drops immediately, and no ack is issued.

## Timing
- Request sampled in cycle n (IDLE).
- Push: ack in cycle n+1; count updated from n+2.
- Pop: RAM read in n+1, ack in n+3; dout valid from n+3 and held.
- Reject: ack+err in cycle n+1.
- Throughput: one push per 2 cycles, one pop per 4 cycles, 1 idle cycle between operations.
- Arbitration cannot starve either side: a waiting requester is served by the next grant.

## Configuration
- STACK_TRAP_EN defined:
  - Adds outputs ovf_trap and unf_trap (1 bit each), plus input trap_clr.
  - These are sticky flags, set on any rejected push or pop (either stack) and cleared by trap_clr or rst.
  - trap_clr has priority over a set in the same cycle.
- Undefined: no trap ports or flags; rejection is reported only through the err pulse.

## Structure
- stack_pkg holds:
  - FSM state enum
  - op encoding (OP_PUSH, OP_POP, OP_BAD)
  - requester id (REQ_DS, REQ_RS)
  - default depth/width constants
- Sub-module stack_ptr(DEPTH), instantiated twice. It holds the pointer register, inc/dec controls, count, full and empty outputs.
- Arbiter, FSM and datapath muxes stay in stack_arbiter.

## Test plan
- Reset, then ds_push with ds_din=0x1234 → mem_we=1 at mem_addr=0, ds_ack in the next cycle; ds_count=1. Then ds_pop → ds_dout=0x1234 with ack 3 cycles after sampling; ds_count=0.
- rs_push 0x7FF, then rs_pop → write at mem_addr=32 (DS_DEPTH); rs_dout=0x7FF; mem_wdata upper bits 0.
- ds_push and rs_push asserted together and held for 4 operations → grants alternate DS, RS, DS, RS; counts end at 2 and 2.
- 32 data pushes then a 33rd → 33rd gets ds_ack+ds_err, no mem_we, ds_full=1. Pop on an empty rs → rs_err=1, rs_dout unchanged. With STACK_TRAP_EN: ovf_trap and unf_trap both set; trap_clr clears them.
- ds_pop asserted, rst pulsed during WAIT → no ds_ack, ds_count=0, state IDLE, and the next push lands at mem_addr=0.
- ds_push and ds_pop asserted together → ds_ack+ds_err in the next cycle, count unchanged.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and default sizing for the StackArch stack RAM arbiter.
package stack_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_RTN_WIDTH  = 11;
    localparam int DEF_DS_DEPTH   = 32;
    localparam int DEF_RS_DEPTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_BAD  = 2'd2
    } op_t;

    typedef enum logic {
        REQ_DS = 1'b0,
        REQ_RS = 1'b1
    } req_t;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer for one region: next-free-slot counter with full/empty status.
module stack_ptr
    import stack_pkg::*;
#(
    parameter int DEPTH = DEF_DS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    input  logic                       dec,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;

    assign full  = (ptr_q == CW'(DEPTH));
    assign empty = (ptr_q == '0);
    assign count = ptr_q;

    // Guards keep the pointer in range even if a caller misbehaves.
    always_comb begin
        ptr_d = ptr_q;
        if (inc && !full) begin
            ptr_d = ptr_q + CW'(1);
        end else if (dec && !empty) begin
            ptr_d = ptr_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one single-port stack RAM between the data and routine stacks with round-robin req/ack arbitration.
// Optional sticky overflow/underflow trap flags are enabled by defining STACK_TRAP_EN.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RTN_WIDTH  = DEF_RTN_WIDTH,
    parameter int DS_DEPTH   = DEF_DS_DEPTH,
    parameter int RS_DEPTH   = DEF_RS_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DS_DEPTH + RS_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ds_push,
    input  logic                          ds_pop,
    input  logic [DATA_WIDTH-1:0]         ds_din,
    output logic [DATA_WIDTH-1:0]         ds_dout,
    output logic                          ds_ack,
    output logic                          ds_err,
    input  logic                          rs_push,
    input  logic                          rs_pop,
    input  logic [RTN_WIDTH-1:0]          rs_din,
    output logic [RTN_WIDTH-1:0]          rs_dout,
    output logic                          rs_ack,
    output logic                          rs_err,
    output logic [$clog2(DS_DEPTH+1)-1:0] ds_count,
    output logic [$clog2(RS_DEPTH+1)-1:0] rs_count,
    output logic                          ds_full,
    output logic                          ds_empty,
    output logic                          rs_full,
    output logic                          rs_empty,
`ifdef STACK_TRAP_EN
    input  logic                          trap_clr,
    output logic                          ovf_trap,
    output logic                          unf_trap,
`endif
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_we,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] RS_BASE = ADDR_WIDTH'(DS_DEPTH);

    state_t                state_q, state_d;
    req_t                  gnt_q, gnt_d;
    req_t                  last_q, last_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] ds_dout_q, ds_dout_d;
    logic [RTN_WIDTH-1:0]  rs_dout_q, rs_dout_d;

    logic ds_req, rs_req;
    req_t sel_gnt;
    logic sel_push, sel_pop, sel_full, sel_empty, sel_reject;
    op_t  sel_op;
    logic ds_inc, ds_dec, rs_inc, rs_dec;

    stack_ptr #(.DEPTH(DS_DEPTH)) u_ds_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (ds_inc),
        .dec   (ds_dec),
        .count (ds_count),
        .full  (ds_full),
        .empty (ds_empty)
    );

    stack_ptr #(.DEPTH(RS_DEPTH)) u_rs_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (rs_inc),
        .dec   (rs_dec),
        .count (rs_count),
        .full  (rs_full),
        .empty (rs_empty)
    );

    assign ds_req = ds_push | ds_pop;
    assign rs_req = rs_push | rs_pop;

    // Round-robin on ties: whoever was not granted last wins.
    always_comb begin
        if (ds_req && rs_req) begin
            if (last_q == REQ_RS) sel_gnt = REQ_DS;
            else                  sel_gnt = REQ_RS;
        end else if (rs_req) begin
            sel_gnt = REQ_RS;
        end else begin
            sel_gnt = REQ_DS;
        end

        if (sel_gnt == REQ_DS) begin
            sel_push  = ds_push;
            sel_pop   = ds_pop;
            sel_full  = ds_full;
            sel_empty = ds_empty;
        end else begin
            sel_push  = rs_push;
            sel_pop   = rs_pop;
            sel_full  = rs_full;
            sel_empty = rs_empty;
        end

        if (sel_push && sel_pop) sel_op = OP_BAD;
        else if (sel_push)       sel_op = OP_PUSH;
        else                     sel_op = OP_POP;

        sel_reject = (sel_op == OP_BAD)
                   || ((sel_op == OP_PUSH) && sel_full)
                   || ((sel_op == OP_POP) && sel_empty);
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        err_d     = err_q;
        din_d     = din_q;
        ds_dout_d = ds_dout_q;
        rs_dout_d = rs_dout_q;
        case (state_q)
            ST_IDLE: begin
                if (ds_req || rs_req) begin
                    gnt_d  = sel_gnt;
                    last_d = sel_gnt;
                    err_d  = sel_reject;
                    din_d  = (sel_gnt == REQ_DS) ? ds_din : DATA_WIDTH'(rs_din);
                    if (sel_reject)            state_d = ST_RESP;
                    else if (sel_op == OP_PUSH) state_d = ST_WR;
                    else                        state_d = ST_RD;
                end
            end
            ST_WR:   state_d = ST_IDLE;
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (gnt_q == REQ_DS) ds_dout_d = mem_rdata;
                else                 rs_dout_d = mem_rdata[RTN_WIDTH-1:0];
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= REQ_DS;
            last_q    <= REQ_RS;
            err_q     <= 1'b0;
            din_q     <= '0;
            ds_dout_q <= '0;
            rs_dout_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            err_q     <= err_d;
            din_q     <= din_d;
            ds_dout_q <= ds_dout_d;
            rs_dout_q <= rs_dout_d;
        end
    end

    assign ds_inc = (state_q == ST_WR) && (gnt_q == REQ_DS);
    assign rs_inc = (state_q == ST_WR) && (gnt_q == REQ_RS);
    assign ds_dec = (state_q == ST_RD) && (gnt_q == REQ_DS);
    assign rs_dec = (state_q == ST_RD) && (gnt_q == REQ_RS);

    // Outputs decode straight from state so an async reset drops mem_we at once.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        case (state_q)
            ST_WR: begin
                mem_we = 1'b1;
                if (gnt_q == REQ_DS) mem_addr = ADDR_WIDTH'(ds_count);
                else                 mem_addr = RS_BASE + ADDR_WIDTH'(rs_count);
            end
            ST_RD: begin
                if (gnt_q == REQ_DS) mem_addr = ADDR_WIDTH'(ds_count) - ADDR_WIDTH'(1);
                else                 mem_addr = RS_BASE + ADDR_WIDTH'(rs_count) - ADDR_WIDTH'(1);
            end
            default: ;
        endcase
    end

    assign mem_wdata = din_q;
    assign ds_dout   = ds_dout_q;
    assign rs_dout   = rs_dout_q;
    assign ds_ack    = ((state_q == ST_WR) || (state_q == ST_RESP)) && (gnt_q == REQ_DS);
    assign rs_ack    = ((state_q == ST_WR) || (state_q == ST_RESP)) && (gnt_q == REQ_RS);
    assign ds_err    = (state_q == ST_RESP) && (gnt_q == REQ_DS) && err_q;
    assign rs_err    = (state_q == ST_RESP) && (gnt_q == REQ_RS) && err_q;

`ifdef STACK_TRAP_EN
    logic ovf_q, unf_q;
    logic ovf_set, unf_set;

    assign ovf_set = (state_q == ST_IDLE) && (ds_req || rs_req) && (sel_op == OP_PUSH) && sel_full;
    assign unf_set = (state_q == ST_IDLE) && (ds_req || rs_req) && (sel_op == OP_POP) && sel_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (trap_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
            unf_q <= unf_q | unf_set;
        end
    end

    assign ovf_trap = ovf_q;
    assign unf_trap = unf_q;
`endif

endmodule
